pipe_ctl: RTL and testbench
===========================

// Module: pipe_ctl
// PURPOSE
//   Pipeline control unit for the 5-stage Y86-64 core (F/D/E/M/W). Decodes hazards from stage icodes/regids
//   and drives per-stage stall/bubble, CC-update enable and the machine-halt state machine. Sits beside the
//   pipeline registers; its stall/bubble outputs feed their load/clear inputs and the PC-select logic.
// PARAMETERS
//   STAT_AOK  4'd1   status code: normal operation
//   STAT_HLT  4'd2   status code: halt executed
//   STAT_ADR  4'd3   status code: bad instruction/data address
//   STAT_INS  4'd4   status code: invalid instruction
//   CNT_W     32     width of performance counters (PIPE_CTL_PERF_EN only)
// PORTS
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   D_icode   in   4   icode in D register
//   d_srcA    in   4   decode source reg A (4'hF = none)
//   d_srcB    in   4   decode source reg B (4'hF = none)
//   E_icode   in   4   icode in E register
//   E_dstM    in   4   E-stage memory destination reg (4'hF = none)
//   e_Cnd     in   1   execute condition result (jXX taken)
//   M_icode   in   4   icode in M register
//   m_stat    in   4   status leaving memory stage
//   W_stat    in   4   status in W register
//   F_stall   out  1   hold F register / PC
//   D_stall   out  1   hold D register
//   D_bubble  out  1   load nop into D
//   E_bubble  out  1   load nop into E
//   M_bubble  out  1   load nop into M
//   W_stall   out  1   hold W register
//   set_cc    out  1   condition-code write enable
//   halted    out  1   registered; 1 once machine has stopped
//   cpu_stat  out  4   registered; final machine status
//   cyc_cnt   out  CNT_W  cycles spent in RUN/DRAIN (PIPE_CTL_PERF_EN only)
//   stl_cnt   out  CNT_W  cycles with F_stall=1 in RUN/DRAIN (PIPE_CTL_PERF_EN only)
// BEHAVIOUR
//   icodes: HALT 0 NOP 1 RRMOV 2 IRMOV 3 RMMOV 4 MRMOV 5 OPQ 6 JXX 7 CALL 8 RET 9 PUSH A POP B.
//   Terms (combinational):
//     load_use = E_icode in {MRMOV,POP} && E_dstM!=F && (E_dstM==d_srcA || E_dstM==d_srcB)
//     ret_pend = RET in {D_icode,E_icode,M_icode};  mispred = E_icode==JXX && !e_Cnd
//     exc_m = m_stat!=STAT_AOK;  exc_w = W_stat!=STAT_AOK
//   Outputs in RUN/DRAIN (combinational, zero latency):
//     F_stall=load_use|ret_pend; D_stall=load_use; D_bubble=mispred|(ret_pend&!load_use)
//     E_bubble=mispred|load_use; M_bubble=exc_m|exc_w; W_stall=exc_w; set_cc=E_icode==OPQ&!exc_m&!exc_w
//   Priority: load_use+ret_pend -> stall D (no D bubble); mispred+ret_pend -> D bubble (bubble wins).
//   FSM (registered, 2-bit): RUN=0, DRAIN=1, HALTED=2.
//     RUN:    exc_w -> HALTED; else exc_m -> DRAIN; else RUN.
//     DRAIN:  exc_w -> HALTED; else !exc_m -> RUN (exception squashed); else DRAIN.
//     HALTED: sticky until rst. Entry edge latches cpu_stat<=W_stat, halted<=1.
//     Illegal state 3 -> HALTED with cpu_stat=STAT_INS.
//   In HALTED: F_stall=D_stall=W_stall=1, all bubbles 0, set_cc=0.
//   While rst=1: all stall/bubble/set_cc outputs forced 0. Async reset: state=RUN, halted=0,
//     cpu_stat=STAT_AOK, counters 0; reset mid-drain or mid-halt returns to RUN immediately.
// CONFIGURATION
//   PIPE_CTL_PERF_EN defined: cyc_cnt/stl_cnt ports present; each increments per cycle per definition,
//     wraps modulo 2^CNT_W, freezes in HALTED, clears on rst.
//   Undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//   E_icode=MRMOV,E_dstM=3,d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0 same cycle.
//   D_icode=RET then RET walks D->E->M over 3 cycles -> F_stall=1,D_bubble=1 each of the 3 cycles, then 0.
//   E_icode=JXX,e_Cnd=0,D_icode=RET -> D_bubble=1,E_bubble=1,F_stall=1,D_stall=0.
//   E_icode=OPQ,m_stat=STAT_ADR -> set_cc=0,M_bubble=1; next edge state=DRAIN; W_stat=STAT_ADR -> HALTED,
//     cpu_stat=3,halted=1, F_stall=D_stall=W_stall=1 held for 10+ cycles.
//   W_stat=STAT_HLT in RUN -> halted=1,cpu_stat=2 next edge; assert rst mid-cycle -> halted=0,cpu_stat=1 at once.
//   PIPE_CTL_PERF_EN: 5 RUN cycles incl. 2 load-use stalls -> cyc_cnt=5, stl_cnt=2; counts frozen after halt.

Source files
------------

// File: rtl/pipe_ctl_if.sv
// Pipeline control interface: hazard inputs from the stage registers and the
// stall/bubble/CC controls returned to them.
// master = pipeline datapath side, slave = pipe_ctl.
interface pipe_ctl_if;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [3:0] m_stat;
    logic [3:0] W_stat;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       set_cc;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );
endinterface

// File: rtl/pipe_ctl.sv
// Pipeline control unit for the 5-stage Y86-64 core.
// Decodes load-use, return and mispredict hazards into per-stage stall/bubble
// controls, gates CC updates on exceptions, and runs the machine-halt FSM.
// Optional feature: define PIPE_CTL_PERF_EN to add the cyc_cnt/stl_cnt
// performance counters.
module pipe_ctl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [3:0]       cpu_stat
`ifdef PIPE_CTL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stl_cnt
`endif
);

  typedef enum logic [3:0] {
    STAT_AOK = 4'd1,
    STAT_HLT = 4'd2,
    STAT_ADR = 4'd3,
    STAT_INS = 4'd4
  } stat_t;

  typedef enum logic [3:0] {
    IC_HALT  = 4'h0,
    IC_NOP   = 4'h1,
    IC_RRMOV = 4'h2,
    IC_IRMOV = 4'h3,
    IC_RMMOV = 4'h4,
    IC_MRMOV = 4'h5,
    IC_OPQ   = 4'h6,
    IC_JXX   = 4'h7,
    IC_CALL  = 4'h8,
    IC_RET   = 4'h9,
    IC_PUSH  = 4'hA,
    IC_POP   = 4'hB
  } icode_t;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic exc_m;
  logic exc_w;

  always_comb begin
    load_use = (E_icode == IC_MRMOV || E_icode == IC_POP) &&
               (E_dstM != REG_NONE) &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    ret_pend = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
    mispred  = (E_icode == IC_JXX) && !e_Cnd;
    exc_m    = (m_stat != STAT_AOK);
    exc_w    = (W_stat != STAT_AOK);
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (!rst) begin
      if (state == RUN || state == DRAIN) begin
        F_stall  = load_use | ret_pend;
        D_stall  = load_use;
        D_bubble = mispred | (ret_pend & ~load_use);
        E_bubble = mispred | load_use;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        set_cc   = (E_icode == IC_OPQ) & ~exc_m & ~exc_w;
      end else begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      halted   <= 1'b0;
      cpu_stat <= STAT_AOK;
    end else begin
      case (state)
        RUN: begin
          if (exc_w) begin
            state    <= HALTED;
            halted   <= 1'b1;
            cpu_stat <= W_stat;
          end else if (exc_m) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (exc_w) begin
            state    <= HALTED;
            halted   <= 1'b1;
            cpu_stat <= W_stat;
          end else if (!exc_m) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state    <= HALTED;
          halted   <= 1'b1;
          cpu_stat <= STAT_INS;
        end
      endcase
    end
  end

`ifdef PIPE_CTL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      stl_cnt <= '0;
    end else if (state == RUN || state == DRAIN) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (F_stall) begin
        stl_cnt <= stl_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed-vector bench for pipe_ctl: hazard decode, priorities, exception
// drain/halt sequence, asynchronous reset and (when enabled) perf counters.
module tb_pipe_ctl;

  logic       clk;
  logic       rst;
  logic [3:0] D_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [3:0] M_icode;
  logic [3:0] m_stat;
  logic [3:0] W_stat;
  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic       set_cc;
  logic       halted;
  logic [3:0] cpu_stat;
`ifdef PIPE_CTL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] stl_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  pipe_ctl #(.CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .W_stall  (W_stall),
    .set_cc   (set_cc),
    .halted   (halted),
    .cpu_stat (cpu_stat)
`ifdef PIPE_CTL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .stl_cnt  (stl_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  task automatic idle_inputs();
    D_icode = 4'h1;
    d_srcA  = 4'hF;
    d_srcB  = 4'hF;
    E_icode = 4'h1;
    E_dstM  = 4'hF;
    e_Cnd   = 1'b1;
    M_icode = 4'h1;
    m_stat  = 4'd1;
    W_stat  = 4'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    E_icode = 4'h5;
    E_dstM  = 4'h3;
    d_srcA  = 4'h3;
    #1;
    check_eq("rst_ctl", 32'(ctl_vec()), 32'b0000000);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_stat", 32'(cpu_stat), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("lu_srcA", 32'(ctl_vec()), 32'b1101000);
    tick();
    d_srcA  = 4'hF;
    E_icode = 4'hB;
    d_srcB  = 4'h3;
    #1;
    check_eq("lu_pop_srcB", 32'(ctl_vec()), 32'b1101000);
    tick();
    idle_inputs();
    E_icode = 4'h5;
    E_dstM  = 4'hF;
    d_srcA  = 4'hF;
    #1;
    check_eq("lu_none_reg", 32'(ctl_vec()), 32'b0000000);
    idle_inputs();
    tick();
    tick();
    tick();
`ifdef PIPE_CTL_PERF_EN
    check_eq("perf_cyc5", cyc_cnt, 32'd5);
    check_eq("perf_stl2", stl_cnt, 32'd2);
`endif

    D_icode = 4'h9;
    #1;
    check_eq("ret_D", 32'(ctl_vec()), 32'b1010000);
    tick();
    D_icode = 4'h1;
    E_icode = 4'h9;
    #1;
    check_eq("ret_E", 32'(ctl_vec()), 32'b1010000);
    tick();
    E_icode = 4'h1;
    M_icode = 4'h9;
    #1;
    check_eq("ret_M", 32'(ctl_vec()), 32'b1010000);
    tick();
    M_icode = 4'h1;
    #1;
    check_eq("ret_gone", 32'(ctl_vec()), 32'b0000000);

    E_icode = 4'h5;
    E_dstM  = 4'h3;
    d_srcA  = 4'h3;
    D_icode = 4'h9;
    #1;
    check_eq("lu_ret", 32'(ctl_vec()), 32'b1101000);
    idle_inputs();

    E_icode = 4'h7;
    e_Cnd   = 1'b0;
    D_icode = 4'h9;
    #1;
    check_eq("mis_ret", 32'(ctl_vec()), 32'b1011000);
    D_icode = 4'h1;
    e_Cnd   = 1'b1;
    #1;
    check_eq("jxx_taken", 32'(ctl_vec()), 32'b0000000);

    E_icode = 4'h6;
    #1;
    check_eq("opq_cc", 32'(ctl_vec()), 32'b0000001);

    m_stat = 4'd3;
    #1;
    check_eq("exc_m_ctl", 32'(ctl_vec()), 32'b0000100);
    tick();
    m_stat = 4'd1;
    tick();
    check_eq("squash_halted", 32'(halted), 32'd0);
    check_eq("squash_ctl", 32'(ctl_vec()), 32'b0000001);

    m_stat = 4'd3;
    #1;
    check_eq("adr_m_ctl", 32'(ctl_vec()), 32'b0000100);
    tick();
    check_eq("drain_halted", 32'(halted), 32'd0);
    m_stat = 4'd1;
    W_stat = 4'd3;
    #1;
    check_eq("drain_exc_w", 32'(ctl_vec()), 32'b0000110);
    tick();
    check_eq("adr_halted", 32'(halted), 32'd1);
    check_eq("adr_stat", 32'(cpu_stat), 32'd3);
    W_stat  = 4'd1;
    E_icode = 4'h7;
    e_Cnd   = 1'b0;
    D_icode = 4'h9;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check_eq("halt_hold", 32'(ctl_vec()), 32'b1100010);
    end
    E_icode = 4'h6;
    #1;
    check_eq("halt_no_cc", 32'(ctl_vec()), 32'b1100010);
    check_eq("halt_sticky_stat", 32'(cpu_stat), 32'd3);

    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_halted", 32'(halted), 32'd0);
    check_eq("mid_rst_stat", 32'(cpu_stat), 32'd1);
    check_eq("mid_rst_ctl", 32'(ctl_vec()), 32'b0000000);
`ifdef PIPE_CTL_PERF_EN
    check_eq("mid_rst_cyc", cyc_cnt, 32'd0);
`endif

    W_stat = 4'd2;
    #1;
    rst = 1'b0;
    #1;
    check_eq("hlt_run_ctl", 32'(ctl_vec()), 32'b0000110);
    check_eq("hlt_pre_edge", 32'(halted), 32'd0);
    tick();
    check_eq("hlt_halted", 32'(halted), 32'd1);
    check_eq("hlt_stat", 32'(cpu_stat), 32'd2);
    W_stat = 4'd1;
    for (int unsigned i = 0; i < 4; i++) tick();
    check_eq("hlt_sticky", 32'(halted), 32'd1);
`ifdef PIPE_CTL_PERF_EN
    check_eq("perf_freeze_cyc", cyc_cnt, 32'd1);
    check_eq("perf_freeze_stl", stl_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
